// File: rtl/logicnet_lut_layer_pipe_if.sv
// Streaming interface for a LUT layer: per-neuron address vectors in,
// per-neuron results out, valid/ready on both sides.
interface logicnet_lut_layer_pipe_if #(
    parameter int N_NEURONS = 4,
    parameter int FAN_IN    = 3,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2
);
    localparam int ADDR_W = FAN_IN * IN_BITS;

    logic                          in_valid;
    logic                          in_ready;
    logic [N_NEURONS*ADDR_W-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NEURONS*OUT_BITS-1:0] out_data;

    // Producer of input vectors and consumer of results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The layer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/logicnet_lut_layer_pipe.sv
// Pipelined layer of truth-table neurons held in runtime-writable
// distributed RAM. Tables are zeroed after reset, then a two-stage
// pipeline (address register, lookup register) streams vectors.
module logicnet_lut_layer_pipe #(
    parameter int N_NEURONS  = 4,
    parameter int FAN_IN     = 3,
    parameter int IN_BITS    = 2,
    parameter int OUT_BITS   = 2,
    localparam int ADDR_W    = FAN_IN * IN_BITS,
    localparam int SEL_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    logicnet_lut_layer_pipe_if.slave stream,
    input  logic                    cfg_we,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [OUT_BITS-1:0]     cfg_data,
    output logic                    cfg_err,
    output logic                    busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {StClear, StRun} state_t;

    state_t                        state;
    logic [ADDR_W-1:0]             clr_cnt;
    logic                          s1_valid;
    logic                          s2_valid;
    logic [N_NEURONS*ADDR_W-1:0]   s1_data;
    logic [N_NEURONS*OUT_BITS-1:0] s2_data;
    logic [N_NEURONS*OUT_BITS-1:0] lookup;
    logic [OUT_BITS-1:0]           lut_mem [N_NEURONS][DEPTH];

    logic sel_ok;
    logic s1_load;
    logic s2_load;
    logic in_ready_w;
    logic in_fire;

    // Unused select codes (non power-of-two layer) count as out of range
    always_comb begin
        sel_ok = 1'b0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (cfg_sel == SEL_W'(k)) sel_ok = 1'b1;
        end
    end

    // Stage handshakes; a config write steals the input slot for its cycle
    always_comb begin
        s2_load    = !s2_valid || stream.out_ready;
        s1_load    = !s1_valid || s2_load;
        in_ready_w = (state == StRun) && !cfg_we && s1_load;
        in_fire    = stream.in_valid && in_ready_w;
    end

    // Asynchronous table read of the address held in S1
    always_comb begin
        lookup = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            lookup[k*OUT_BITS +: OUT_BITS] = lut_mem[k][s1_data[k*ADDR_W +: ADDR_W]];
        end
    end

    assign stream.in_ready  = in_ready_w;
    assign stream.out_valid = s2_valid;
    assign stream.out_data  = s2_data;

    // Table storage: sweep-clear in StClear, config writes otherwise (no reset on RAM)
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_NEURONS; k++) begin
            if (state == StClear) begin
                lut_mem[k][clr_cnt] <= '0;
            end else if (rst && cfg_we && cfg_sel == SEL_W'(k)) begin
                lut_mem[k][cfg_addr] <= cfg_data;
            end
        end
    end

    // Clear/run FSM, error pulse and pipeline valid/data registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= StClear;
            clr_cnt  <= '0;
            busy     <= 1'b1;
            cfg_err  <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '0;
            s2_data  <= '0;
        end else begin
            unique case (state)
                StClear: begin
                    cfg_err <= cfg_we;
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= StRun;
                        busy  <= 1'b0;
                    end
                end
                StRun: begin
                    cfg_err <= cfg_we && !sel_ok;
                end
                default: begin
                    state <= StClear;
                end
            endcase

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_data <= lookup;
            end
            if (s1_load) begin
                s1_valid <= in_fire;
                if (in_fire) s1_data <= stream.in_data;
            end
        end
    end
endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// Self-checking bench for the LUT layer: table-driven vectors, scoreboard
// queue of expected results, hand sequences for clear/config corner cases.
module tb_logicnet_lut_layer_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Main instance, default 4 neurons
    logicnet_lut_layer_pipe_if #(.N_NEURONS(4)) bus ();
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [5:0] cfg_addr;
    logic [1:0] cfg_data;
    logic       cfg_err;
    logic       busy;

    logicnet_lut_layer_pipe #(.N_NEURONS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .stream   (bus),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .busy     (busy)
    );

    // Second instance with 3 neurons, so select code 3 is unused
    logicnet_lut_layer_pipe_if #(.N_NEURONS(3)) bus2 ();
    logic       cfg2_we;
    logic [1:0] cfg2_sel;
    logic [5:0] cfg2_addr;
    logic [1:0] cfg2_data;
    logic       cfg2_err;
    logic       busy2;

    logicnet_lut_layer_pipe #(.N_NEURONS(3)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .stream   (bus2),
        .cfg_we   (cfg2_we),
        .cfg_sel  (cfg2_sel),
        .cfg_addr (cfg2_addr),
        .cfg_data (cfg2_data),
        .cfg_err  (cfg2_err),
        .busy     (busy2)
    );

    typedef struct {
        logic [23:0] din;
        logic [7:0]  dout;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] addr;
        logic [1:0] data;
    } wr_t;

    vec_t vecs [7];
    wr_t  wrs  [6];

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [$];
    int         out_t [$];
    logic       held_v = 1'b0;
    logic [7:0] held_d;
    bit         bp_en  = 1'b0;
    int         bp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on transfer, stability while stalled
    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(held_d));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_t.push_back(cyc_cnt);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h, expected no output", bus.out_data);
                end else begin
                    check("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
        end
    end

    task automatic send(input logic [23:0] d, input logic [7:0] e);
        int   n     = 0;
        logic fired = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!fired && n < 50) begin
            bus.out_ready = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
            bp_cnt++;
            @(negedge clk);
            fired = bus.in_ready;
            if (fired) exp_q.push_back(e);
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!fired) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance of %0h", d);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() > 0 && n < 100) begin
            bus.out_ready = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
            bp_cnt++;
            step();
            n++;
        end
        bus.out_ready = 1'b1;
        repeat (3) step();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [5:0] addr, input logic [1:0] data);
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        cfg_we   = 1'b1;
        #1;
        check("wr_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("wr_err", 32'(cfg_err), 32'd0);
        cfg_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        vecs[0] = '{{6'd0, 6'd0, 6'd0, 6'b101000}, 8'b00000011};
        vecs[1] = '{{6'd1, 6'd1, 6'd1, 6'b001010}, 8'b00000010};
        vecs[2] = '{{6'd33, 6'd63, 6'd7, 6'd5}, 8'b10110100};
        vecs[3] = '{{6'd33, 6'd0, 6'd20, 6'b101000}, 8'b10001111};
        vecs[4] = '{{6'd0, 6'd63, 6'd7, 6'b001010}, 8'b00110110};
        vecs[5] = '{{6'd33, 6'd63, 6'd20, 6'd0}, 8'b10111100};
        vecs[6] = '{{6'd0, 6'd0, 6'd0, 6'd0}, 8'b00000000};
        wrs[0]  = '{2'd0, 6'b101000, 2'b11};
        wrs[1]  = '{2'd0, 6'b001010, 2'b10};
        wrs[2]  = '{2'd1, 6'd7, 2'b01};
        wrs[3]  = '{2'd2, 6'd63, 2'b11};
        wrs[4]  = '{2'd3, 6'd33, 2'b10};
        wrs[5]  = '{2'd1, 6'd20, 2'b11};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        cfg2_we = 1'b0; cfg2_sel = '0; cfg2_addr = '0; cfg2_data = '0;

        // Reset values
        rst = 1'b0;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Clear sweep length, with a rejected write at cycle 10
        rst = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (cyc == 10) begin
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 6'd5; cfg_data = 2'b11;
            end else begin
                cfg_we = 1'b0;
            end
            step();
            cyc++;
            if (cyc == 11) check("clear_cfg_err", 32'(cfg_err), 32'd1);
            if (cyc == 12) check("clear_cfg_err_pulse", 32'(cfg_err), 32'd0);
            if (cyc < 64) check("clear_in_ready", 32'(bus.in_ready), 32'd0);
        end
        cfg_we = 1'b0;
        #1;
        check("clear_cycles", 32'(cyc), 32'd64);
        check("run_in_ready", 32'(bus.in_ready), 32'd1);

        // Two-cycle latency, zeroed tables
        bus.in_valid = 1'b1;
        bus.in_data  = {6'd3, 6'd17, 6'd42, 6'd9};
        exp_q.push_back(8'h00);
        step();
        bus.in_valid = 1'b0;
        check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
        check("lat_cycle2_data", 32'(bus.out_data), 32'd0);
        step();
        check("lat_single", 32'(bus.out_valid), 32'd0);

        // Program tables
        for (int i = 0; i < 6; i++) cfg_write(wrs[i].sel, wrs[i].addr, wrs[i].data);

        // Back-to-back pair, full throughput
        out_t.delete();
        send(vecs[0].din, vecs[0].dout);
        send(vecs[1].din, vecs[1].dout);
        drain("pair_drain");
        check("pair_count", 32'(out_t.size()), 32'd2);
        if (out_t.size() == 2) check("pair_consecutive", 32'(out_t[1] - out_t[0]), 32'd1);

        // Five vectors under 1,0,0 backpressure
        bp_en  = 1'b1;
        bp_cnt = 0;
        out_t.delete();
        for (int i = 2; i < 7; i++) send(vecs[i].din, vecs[i].dout);
        drain("bp_drain");
        bp_en = 1'b0;
        check("bp_count", 32'(out_t.size()), 32'd5);

        // Write racing a lookup already in S1
        send({18'd0, 6'd9}, 8'h00);
        cfg_write(2'd0, 6'd9, 2'b01);
        send({18'd0, 6'd9}, 8'h01);
        drain("race_drain");

        // Out-of-range select on the 3-neuron layer
        #1;
        check("oor_ready_idle", 32'(bus2.in_ready), 32'd1);
        cfg2_we = 1'b1; cfg2_sel = 2'd3; cfg2_addr = 6'd5; cfg2_data = 2'b11;
        #1;
        check("oor_in_ready", 32'(bus2.in_ready), 32'd0);
        step();
        check("oor_err", 32'(cfg2_err), 32'd1);
        cfg2_we = 1'b0;
        step();
        check("oor_err_pulse", 32'(cfg2_err), 32'd0);
        cfg2_we = 1'b1; cfg2_sel = 2'd2; cfg2_addr = 6'd6; cfg2_data = 2'b01;
        step();
        check("ok_err", 32'(cfg2_err), 32'd0);
        cfg2_we = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_data  = {6'd5, 6'd5, 6'd5};
        step();
        bus2.in_data  = {6'd6, 6'd6, 6'd6};
        step();
        bus2.in_valid = 1'b0;
        check("oor_lookup_valid", 32'(bus2.out_valid), 32'd1);
        check("oor_lookup_data", 32'(bus2.out_data), 32'd0);
        step();
        check("ok_lookup_data", 32'(bus2.out_data), 32'b010000);
        step();
        check("dut2_idle_valid", 32'(bus2.out_valid), 32'd0);

        // Reset with data in flight: no output afterwards
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = vecs[3].din;
        step();
        bus.in_valid  = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        check("flush_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("flush_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logicnet_lut_layer_pipe.md
Name: logicnet_lut_layer_pipe

Overview:
- Parametrised, pipelined successor to the fixed combinational LogicNet neuron ROM.
- Implements N_NEURONS truth-table neurons, each mapping FAN_IN inputs of IN_BITS bits to OUT_BITS bits.
- Truth tables live in runtime-writable distributed RAM rather than hard-coded case statements, so a layer can be retrained without resynthesis.
- Sits between a quantised-feature front end (or a previous layer) and the next layer, using valid/ready streaming on both sides.

Parameters:
- N_NEURONS, 4, number of neurons in the layer.
- FAN_IN, 3, inputs per neuron.
- IN_BITS, 2, bits per neuron input.
- OUT_BITS, 2, bits per neuron output.
- ADDR_W, FAN_IN*IN_BITS (derived, not overridable), table address width; table depth is 2^ADDR_W.
- SEL_W, clog2(N_NEURONS) with minimum 1 (derived), neuron select width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  layer accepts input this cycle.
- in_data  in  N_NEURONS*ADDR_W  per-neuron address vectors; neuron k uses bits [k*ADDR_W +: ADDR_W]; input j of a neuron occupies bits [j*IN_BITS +: IN_BITS].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  N_NEURONS*OUT_BITS  neuron k result at [k*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  table write strobe.
- cfg_sel  in  SEL_W  target neuron.
- cfg_addr  in  ADDR_W  table entry.
- cfg_data  in  OUT_BITS  entry value.
- cfg_err  out  1  one-cycle pulse: write rejected.
- busy  out  1  table clear in progress.

Behaviour:
- FSM states are CLEAR and RUN.
- rst low at a clock edge: enter CLEAR, set clear counter to 0, and empty both pipeline stages. Reset values: out_valid=0, out_data=0, cfg_err=0, busy=1, in_ready=0.
- Reset mid-operation discards in-flight data with no output.
- CLEAR: each cycle, write 0 to entry [counter] of every neuron table, then increment the counter.
  - After entry 2^ADDR_W-1 is written, move to RUN on the next edge. CLEAR lasts exactly 2^ADDR_W cycles (64 at defaults).
  - busy=1 and in_ready=0 throughout CLEAR.
  - cfg_we asserted during CLEAR is ignored and pulses cfg_err the following cycle.
- RUN: busy=0.
- Pipeline stage S1 registers in_data. Stage S2 registers the table lookup of S1's address for every neuron.
  - Latency is 2 cycles from accepted input to out_valid when out_ready=1.
- Each stage has a valid bit. A stage loads when it is empty or its contents move on this cycle.
- in_ready = RUN & !cfg_we & (!S1_valid | S2 can load).
  - S2 can load = !S2_valid | out_ready.
- out_valid = S2_valid. out_data holds stable while out_valid & !out_ready.
- Full throughput is 1 vector/cycle with out_ready held high. Backpressure stalls both stages without loss or duplication.
- Config write in RUN: if cfg_sel < N_NEURONS, table[cfg_sel][cfg_addr] <= cfg_data at the edge. Otherwise no write and cfg_err pulses one cycle later.
- Write priority: cfg_we deasserts in_ready the same cycle, so no new input is accepted alongside a write. Lookups already in S1 proceed.
- Read/write ordering: the lookup is asynchronous-read and is registered into S2.
  - A write at edge t is visible to S2 loads at edge t+1 and later.
  - A lookup registered at edge t sees the old value.
- Unused cfg_sel codes (N_NEURONS not a power of 2) are out of range and handled as above.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release. Expect busy=1 for exactly 64 cycles, then busy=0 and in_ready=1. Any input in_data then yields out_data=0 with out_valid 2 cycles after acceptance.
- Program neuron 0: addr 6'b101000 -> 2'b11, addr 6'b001010 -> 2'b10. Stream those two vectors back-to-back with out_ready=1. Expect out_data[1:0] = 11 then 10 on consecutive cycles, and other neurons 00.
- Backpressure: stream 5 distinct programmed vectors with out_ready toggling 1,0,0,1,... Expect all 5 results in order with no duplicates and out_data stable during stalls.
- Config during CLEAR: assert cfg_we at cycle 10 after reset. Expect cfg_err=1 at cycle 11 and the table entry still 0 after CLEAR.
- Out-of-range write: N_NEURONS=3, cfg_sel=3. Expect cfg_err pulse, no table change, and in_ready=0 during the write cycle.
- Write/lookup race: with S1 holding addr A, write table[0][A]=01 (old value 00) in the same cycle. Expect result 00. An immediately following lookup of A returns 01.
